// File: rtl/quant.sv
// quant: H.265 coefficient quantiser / dequantiser with a 3-stage pipeline, TU framing and coded-block flag.
// Optional build macro QUANT_CLIP_EN: saturate results to signed 16 bits instead of truncating.
module quant #(
  parameter int LANES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_valid,
  input  logic                  inverse,
  input  logic [1:0]            i_transize,
  input  logic [15:0]           Q,
  input  logic [27:0]           offset,
  input  logic [4:0]            shift,
  input  logic [16*LANES-1:0]   i_coef,
  output logic                  o_valid,
  output logic [16*LANES-1:0]   o_coef,
  output logic                  o_last,
  output logic                  o_cbf
);
  localparam int LG = $clog2(LANES);

  logic [9:0]  cnt_q, cnt_d;
  logic        inv_hold_q;
  logic [1:0]  ts_hold_q;
  logic [15:0] q_hold_q;
  logic [27:0] off_hold_q;
  logic [4:0]  sh_hold_q;

  logic        first_s, inv_s, last_s;
  logic [1:0]  ts_s;
  logic [15:0] q_s;
  logic [27:0] off_s;
  logic [4:0]  sh_s;
  logic [3:0]  lg_beats_s;
  logic [10:0] beats_s;

  logic                   s1_valid_q, s1_last_q, s1_inv_q;
  logic [15:0]            s1_q_q;
  logic [27:0]            s1_off_q;
  logic [4:0]             s1_sh_q;
  logic [LANES-1:0][15:0] s1_x_q, s1_x_d;
  logic [LANES-1:0]       s1_neg_q, s1_neg_d;

  logic                   s2_valid_q, s2_last_q, s2_inv_q;
  logic [27:0]            s2_off_q;
  logic [4:0]             s2_sh_q;
  logic [LANES-1:0]       s2_neg_q;
  logic [LANES-1:0][31:0] s2_m_q, s2_m_d;

  logic [LANES-1:0][15:0] res_s;
  logic [16*LANES-1:0]    o_coef_d;
  logic                   nz_s, cbf_acc_q, cbf_acc_d, o_cbf_d;

  // Offset add, shift and narrowing for one lane; forward mode works on magnitudes.
  function automatic logic [15:0] lane_result(input logic inv, input logic neg,
                                              input logic [31:0] m, input logic [27:0] off,
                                              input logic [4:0] sh);
    logic [32:0] sum;
    logic [15:0] mag;
    logic [15:0] r;
`ifdef QUANT_CLIP_EN
    logic signed [32:0] shr;
`endif
    sum = (inv ? {m[31], m} : {1'b0, m}) + {{5{off[27]}}, off};
`ifdef QUANT_CLIP_EN
    if (inv) begin
      shr = $signed(sum) >>> sh;
      mag = 16'd0;
      if (shr > 33'sd32767) begin
        r = 16'h7FFF;
      end else if (shr < -33'sd32768) begin
        r = 16'h8000;
      end else begin
        r = shr[15:0];
      end
    end else begin
      shr = $signed(sum >> sh);
      mag = (shr[32:15] != 18'd0) ? 16'h7FFF : shr[15:0];
      r   = neg ? 16'(16'd0 - mag) : mag;
    end
`else
    if (inv) begin
      mag = 16'd0;
      r   = 16'($signed(sum) >>> sh);
    end else begin
      mag = 16'(sum >> sh);
      r   = neg ? 16'(16'd0 - mag) : mag;
    end
`endif
    return r;
  endfunction

  // Beat framing, live-versus-held parameter select and stage-1 operand prep
  always_comb begin
    first_s = (cnt_q == 10'd0);
    if (first_s) begin
      inv_s = inverse;
      ts_s  = i_transize;
      q_s   = Q;
      off_s = offset;
      sh_s  = shift;
    end else begin
      inv_s = inv_hold_q;
      ts_s  = ts_hold_q;
      q_s   = q_hold_q;
      off_s = off_hold_q;
      sh_s  = sh_hold_q;
    end
    lg_beats_s = 4'd4 + {1'b0, ts_s, 1'b0} - 4'(LG);
    beats_s    = 11'd1 << lg_beats_s;
    last_s     = (cnt_q == 10'(beats_s - 11'd1));
    if (i_valid) begin
      cnt_d = last_s ? 10'd0 : cnt_q + 10'd1;
    end else begin
      cnt_d = cnt_q;
    end
    for (int k = 0; k < LANES; k++) begin
      s1_neg_d[k] = i_coef[16*k+15];
      if (inv_s || !i_coef[16*k+15]) begin
        s1_x_d[k] = i_coef[16*k +: 16];
      end else begin
        s1_x_d[k] = 16'(16'd0 - i_coef[16*k +: 16]);
      end
    end
  end

  // Beat counter, held TU parameters and stage-1 capture
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q      <= 10'd0;
      inv_hold_q <= 1'b0;
      ts_hold_q  <= 2'd0;
      q_hold_q   <= 16'd0;
      off_hold_q <= 28'd0;
      sh_hold_q  <= 5'd0;
      s1_valid_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_inv_q   <= 1'b0;
      s1_q_q     <= 16'd0;
      s1_off_q   <= 28'd0;
      s1_sh_q    <= 5'd0;
      s1_x_q     <= '0;
      s1_neg_q   <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (i_valid && first_s) begin
        inv_hold_q <= inverse;
        ts_hold_q  <= i_transize;
        q_hold_q   <= Q;
        off_hold_q <= offset;
        sh_hold_q  <= shift;
      end
      s1_valid_q <= i_valid;
      s1_last_q  <= i_valid & last_s;
      s1_inv_q   <= inv_s;
      s1_q_q     <= q_s;
      s1_off_q   <= off_s;
      s1_sh_q    <= sh_s;
      s1_x_q     <= s1_x_d;
      s1_neg_q   <= s1_neg_d;
    end
  end

  // Stage-2 products: unsigned magnitude*Q forward, signed c*Q inverse
  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      if (s1_inv_q) begin
        s2_m_d[k] = $signed({{16{s1_x_q[k][15]}}, s1_x_q[k]}) * $signed({{16{s1_q_q[15]}}, s1_q_q});
      end else begin
        s2_m_d[k] = {16'd0, s1_x_q[k]} * {16'd0, s1_q_q};
      end
    end
  end

  // Stage-2 register
  always_ff @(posedge clk) begin
    if (!rst) begin
      s2_valid_q <= 1'b0;
      s2_last_q  <= 1'b0;
      s2_inv_q   <= 1'b0;
      s2_off_q   <= 28'd0;
      s2_sh_q    <= 5'd0;
      s2_neg_q   <= '0;
      s2_m_q     <= '0;
    end else begin
      s2_valid_q <= s1_valid_q;
      s2_last_q  <= s1_last_q;
      s2_inv_q   <= s1_inv_q;
      s2_off_q   <= s1_off_q;
      s2_sh_q    <= s1_sh_q;
      s2_neg_q   <= s1_neg_q;
      s2_m_q     <= s2_m_d;
    end
  end

  // Stage-3 results and coded-block flag accumulation
  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      res_s[k] = lane_result(s2_inv_q, s2_neg_q[k], s2_m_q[k], s2_off_q, s2_sh_q);
    end
    nz_s = |res_s;
    if (s2_valid_q) begin
      o_coef_d = res_s;
      if (s2_last_q) begin
        o_cbf_d   = cbf_acc_q | nz_s;
        cbf_acc_d = 1'b0;
      end else begin
        o_cbf_d   = 1'b0;
        cbf_acc_d = cbf_acc_q | nz_s;
      end
    end else begin
      o_coef_d  = o_coef;
      o_cbf_d   = 1'b0;
      cbf_acc_d = cbf_acc_q;
    end
  end

  // Output register
  always_ff @(posedge clk) begin
    if (!rst) begin
      o_valid   <= 1'b0;
      o_last    <= 1'b0;
      o_cbf     <= 1'b0;
      o_coef    <= '0;
      cbf_acc_q <= 1'b0;
    end else begin
      o_valid   <= s2_valid_q;
      o_last    <= s2_valid_q & s2_last_q;
      o_cbf     <= o_cbf_d;
      o_coef    <= o_coef_d;
      cbf_acc_q <= cbf_acc_d;
    end
  end

endmodule
